// File: rtl/pingpong_buffer_pkg.sv
// Shared constants for the ping-pong bank buffer:
// default geometry and the bit positions inside the sticky error vector.
package pingpong_buffer_pkg;

    localparam int DEF_LANES     = 16;
    localparam int DEF_LANE_W    = 24;
    localparam int DEF_DEPTH     = 16;
    localparam int DEF_NUM_BANKS = 2;

    localparam int ERR_OVF = 0;
    localparam int ERR_UDF = 1;

endpackage

// File: rtl/pingpong_buffer_bank.sv
// One storage bank: register array with a lane-masked write port
// and an unregistered read port. Contents are not reset.
module pingpong_buffer_bank
    import pingpong_buffer_pkg::*;
#(
    parameter int LANES  = DEF_LANES,
    parameter int LANE_W = DEF_LANE_W,
    parameter int DEPTH  = DEF_DEPTH,
    localparam int W      = LANES * LANE_W,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [LANES-1:0]  wr_mask,
    input  logic [W-1:0]      wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [W-1:0]      rd_data
);

    logic [W-1:0] mem [DEPTH];

    // Update only the lanes whose mask bit is set; others keep their value.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int k = 0; k < LANES; k++) begin
                if (wr_mask[k]) begin
                    mem[wr_addr][k*LANE_W +: LANE_W] <= wr_data[k*LANE_W +: LANE_W];
                end
            end
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/pingpong_buffer.sv
// Multi-bank ping-pong buffer: producer fills bank wr_ptr while the
// consumer drains committed bank rd_ptr; banks rotate round-robin.
module pingpong_buffer
    import pingpong_buffer_pkg::*;
#(
    parameter int LANES     = DEF_LANES,
    parameter int LANE_W    = DEF_LANE_W,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int NUM_BANKS = DEF_NUM_BANKS,
    localparam int W      = LANES * LANE_W,
    localparam int ADDR_W = $clog2(DEPTH),
    localparam int BANK_W = (NUM_BANKS > 2) ? $clog2(NUM_BANKS) : 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [LANES-1:0]  i_wr_mask,
    input  logic [W-1:0]      i_wr_data,
    input  logic              i_wr_commit,
    output logic              o_wr_ready,
    output logic              o_rd_avail,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [W-1:0]      o_rd_data,
    output logic              o_rd_valid,
    input  logic              i_rd_release,
    output logic [BANK_W-1:0] o_wr_bank,
    output logic [BANK_W-1:0] o_rd_bank,
    output logic [1:0]        o_err
);

    localparam int CNT_W = $clog2(NUM_BANKS + 1);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(NUM_BANKS);
    localparam logic [BANK_W-1:0] PTR_LAST = BANK_W'(NUM_BANKS - 1);
    localparam logic [ADDR_W:0]   ADDR_LIM = (ADDR_W + 1)'(DEPTH);

    logic [BANK_W-1:0] wr_ptr;
    logic [BANK_W-1:0] rd_ptr;
    logic [CNT_W-1:0]  full_cnt;

    logic wr_addr_ok;
    logic rd_addr_ok;
    logic wr_fire;
    logic commit_fire;
    logic rd_fire;
    logic release_fire;

    logic [NUM_BANKS-1:0] bank_we;
    logic [W-1:0]         bank_rd [NUM_BANKS];

    function automatic logic [BANK_W-1:0] next_ptr(input logic [BANK_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    assign o_wr_ready = (full_cnt != CNT_FULL);
    assign o_rd_avail = (full_cnt != '0);
    assign o_wr_bank  = wr_ptr;
    assign o_rd_bank  = rd_ptr;

    assign wr_addr_ok   = ({1'b0, i_wr_addr} < ADDR_LIM);
    assign rd_addr_ok   = ({1'b0, i_rd_addr} < ADDR_LIM);
    assign wr_fire      = i_wr_en & o_wr_ready & wr_addr_ok;
    assign commit_fire  = i_wr_commit & o_wr_ready;
    assign rd_fire      = i_rd_en & o_rd_avail;
    assign release_fire = i_rd_release & o_rd_avail;

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        assign bank_we[b] = wr_fire && (wr_ptr == BANK_W'(b));

        pingpong_buffer_bank #(
            .LANES  (LANES),
            .LANE_W (LANE_W),
            .DEPTH  (DEPTH)
        ) u_bank (
            .clk     (i_clk),
            .we      (bank_we[b]),
            .wr_addr (i_wr_addr),
            .wr_mask (i_wr_mask),
            .wr_data (i_wr_data),
            .rd_addr (i_rd_addr),
            .rd_data (bank_rd[b])
        );
    end

    // Rotate fill/drain pointers and track how many banks are committed.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            full_cnt <= '0;
        end else begin
            if (commit_fire) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (release_fire) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            if (commit_fire && !release_fire) begin
                full_cnt <= full_cnt + 1'b1;
            end else if (!commit_fire && release_fire) begin
                full_cnt <= full_cnt - 1'b1;
            end
        end
    end

    // Sticky flags: producer action when full, consumer action when empty.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_err <= '0;
        end else begin
            if ((i_wr_en | i_wr_commit) & ~o_wr_ready) begin
                o_err[ERR_OVF] <= 1'b1;
            end
            if ((i_rd_en | i_rd_release) & ~o_rd_avail) begin
                o_err[ERR_UDF] <= 1'b1;
            end
        end
    end

    // Registered read from the drain bank; data holds when idle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_rd_data  <= '0;
            o_rd_valid <= 1'b0;
        end else begin
            o_rd_valid <= rd_fire;
            if (rd_fire) begin
                o_rd_data <= rd_addr_ok ? bank_rd[rd_ptr] : '0;
            end
        end
    end

endmodule

// File: tb/tb_pingpong_buffer.sv
// Directed self-checking bench for pingpong_buffer with default
// parameters (16 x 24-bit lanes, depth 16, two banks).
module tb_pingpong_buffer;

    localparam int W = 384;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [3:0]    wr_addr;
    logic [15:0]   wr_mask;
    logic [W-1:0]  wr_data;
    logic          wr_commit;
    logic          wr_ready;
    logic          rd_avail;
    logic          rd_en;
    logic [3:0]    rd_addr;
    logic [W-1:0]  rd_data;
    logic          rd_valid;
    logic          rd_release;
    logic [0:0]    wr_bank;
    logic [0:0]    rd_bank;
    logic [1:0]    err;

    int tests = 0;
    int fails = 0;

    logic [W-1:0] exp_mask;

    always #5 clk = ~clk;

    pingpong_buffer dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_wr_en      (wr_en),
        .i_wr_addr    (wr_addr),
        .i_wr_mask    (wr_mask),
        .i_wr_data    (wr_data),
        .i_wr_commit  (wr_commit),
        .o_wr_ready   (wr_ready),
        .o_rd_avail   (rd_avail),
        .i_rd_en      (rd_en),
        .i_rd_addr    (rd_addr),
        .o_rd_data    (rd_data),
        .o_rd_valid   (rd_valid),
        .i_rd_release (rd_release),
        .o_wr_bank    (wr_bank),
        .o_rd_bank    (rd_bank),
        .o_err        (err)
    );

    task automatic check(input string tag, input logic [W-1:0] got,
                         input logic [W-1:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en      = 1'b0;
        wr_addr    = '0;
        wr_mask    = '0;
        wr_data    = '0;
        wr_commit  = 1'b0;
        rd_en      = 1'b0;
        rd_addr    = '0;
        rd_release = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // 1: reset state
        check("rst_wr_ready", W'(wr_ready), W'(1));
        check("rst_rd_avail", W'(rd_avail), W'(0));
        check("rst_rd_valid", W'(rd_valid), W'(0));
        check("rst_err", W'(err), W'(0));
        check("rst_wr_bank", W'(wr_bank), W'(0));
        check("rst_rd_bank", W'(rd_bank), W'(0));
        check("rst_rd_data", rd_data, W'(0));

        // 2: fill bank 0 with data = addr, commit, read addr 5
        for (int a = 0; a < 16; a++) begin
            wr_en   = 1'b1;
            wr_addr = 4'(a);
            wr_mask = 16'hFFFF;
            wr_data = W'(a);
            tick();
        end
        idle();
        wr_commit = 1'b1;
        tick();
        idle();
        check("c1_rd_avail", W'(rd_avail), W'(1));
        check("c1_wr_bank", W'(wr_bank), W'(1));
        rd_en   = 1'b1;
        rd_addr = 4'd5;
        tick();
        idle();
        check("rd5_valid", W'(rd_valid), W'(1));
        check("rd5_data", rd_data, W'(5));
        tick();
        check("rd_idle_valid", W'(rd_valid), W'(0));
        check("rd_idle_hold", rd_data, W'(5));

        // 3: lane mask into bank 1 addr 3, then commit -> full
        wr_en   = 1'b1;
        wr_addr = 4'd3;
        wr_mask = 16'hFFFF;
        wr_data = '1;
        tick();
        wr_mask = 16'h0001;
        wr_data = '0;
        tick();
        idle();
        wr_commit = 1'b1;
        tick();
        idle();
        check("full_wr_ready", W'(wr_ready), W'(0));
        check("full_wr_bank", W'(wr_bank), W'(0));

        // 4: write while full is dropped and flags overflow
        wr_en   = 1'b1;
        wr_addr = 4'd3;
        wr_mask = 16'hFFFF;
        wr_data = W'(24'h123);
        tick();
        idle();
        check("ovf_err", W'(err), W'(2'b01));
        rd_release = 1'b1;
        tick();
        idle();
        check("rel_wr_ready", W'(wr_ready), W'(1));
        check("rel_wr_bank", W'(wr_bank), W'(0));
        check("rel_rd_bank", W'(rd_bank), W'(1));
        rd_en   = 1'b1;
        rd_addr = 4'd3;
        tick();
        idle();
        exp_mask = {{15{24'hFFFFFF}}, 24'h000000};
        check("mask_rd_data", rd_data, exp_mask);

        // 5: write+commit+release in one cycle with one bank full
        wr_en      = 1'b1;
        wr_addr    = 4'd7;
        wr_mask    = 16'hFFFF;
        wr_data    = W'(24'hABCDE);
        wr_commit  = 1'b1;
        rd_release = 1'b1;
        tick();
        idle();
        check("cr_wr_bank", W'(wr_bank), W'(1));
        check("cr_rd_bank", W'(rd_bank), W'(0));
        check("cr_rd_avail", W'(rd_avail), W'(1));
        check("cr_wr_ready", W'(wr_ready), W'(1));
        rd_en   = 1'b1;
        rd_addr = 4'd7;
        tick();
        idle();
        check("cr_rd_data", rd_data, W'(24'hABCDE));
        rd_en      = 1'b1;
        rd_addr    = 4'd5;
        rd_release = 1'b1;
        tick();
        idle();
        check("relrd_data", rd_data, W'(5));
        check("relrd_avail", W'(rd_avail), W'(0));

        // 6: underflow from an empty buffer, then reset mid-fill
        do_reset();
        tick();
        check("rst2_err", W'(err), W'(0));
        rd_en      = 1'b1;
        rd_release = 1'b1;
        tick();
        idle();
        check("udf_err", W'(err), W'(2'b10));
        check("udf_rd_valid", W'(rd_valid), W'(0));
        check("udf_rd_bank", W'(rd_bank), W'(0));
        wr_en     = 1'b1;
        wr_addr   = 4'd2;
        wr_mask   = 16'hFFFF;
        wr_data   = W'(24'h77);
        wr_commit = 1'b1;
        tick();
        idle();
        rd_en   = 1'b1;
        rd_addr = 4'd2;
        tick();
        idle();
        check("pre_rst_data", rd_data, W'(24'h77));
        check("pre_rst_wr_bank", W'(wr_bank), W'(1));
        rst   = 1'b1;
        rd_en = 1'b1;
        tick();
        rst = 1'b0;
        idle();
        check("mid_rst_wr_ready", W'(wr_ready), W'(1));
        check("mid_rst_rd_avail", W'(rd_avail), W'(0));
        check("mid_rst_rd_valid", W'(rd_valid), W'(0));
        check("mid_rst_rd_data", rd_data, W'(0));
        check("mid_rst_err", W'(err), W'(0));
        check("mid_rst_wr_bank", W'(wr_bank), W'(0));
        check("mid_rst_rd_bank", W'(rd_bank), W'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
